instruction_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the decode/control stage.
- Holds the program counter and issues requests to instruction memory over a req/gnt/rvalid handshake, with one request outstanding at most.
- Captures each returned word into the IF/ID register, which drives decode; Opcode_o feeds the control unit's opcode input.
- Handles decode-stage stall and branch/jump redirect (flush), including redirects that arrive while a memory request is in flight.

---
 rtl/instruction_fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, single-outstanding req/gnt/rvalid instruction-memory port, skid buffer and IF/ID register.
// Optional macro FETCH_MISALIGN_CHECK_EN adds Misalign_o and a HALT state on misaligned redirects.
module instruction_fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h0040_0000),
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Stall_i,
    input  logic            Branch_Taken_i,
    input  logic [XLEN-1:0] Branch_Target_i,
    output logic            Imem_Req_o,
    output logic [XLEN-1:0] Imem_Addr_o,
    input  logic            Imem_Gnt_i,
    input  logic            Imem_Rvalid_i,
    input  logic [31:0]     Imem_Rdata_i,
    output logic [31:0]     Instr_o,
    output logic [6:0]      Opcode_o,
    output logic [XLEN-1:0] PC_o,
    output logic [XLEN-1:0] PC_Plus4_o,
    output logic            Instr_Valid_o
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            Misalign_o
`endif
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_KILL,
        S_HALT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [31:0]     id_instr_q, id_instr_d;
    logic            id_valid_q, id_valid_d;
    logic [31:0]     skid_q, skid_d;
    logic [XLEN-1:0] target;
    logic            load;
    logic [31:0]     load_data;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic            misalign_q, misalign_d;
`endif

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target = Branch_Target_i;
`else
    assign target = Branch_Target_i & ~XLEN'(3);
`endif

    // Reset gates the request so nothing is issued while the FSM is held.
    assign Imem_Req_o    = (state_q == S_FETCH) && !reset;
    assign Imem_Addr_o   = pc_q;
    assign Instr_o       = id_instr_q;
    assign Opcode_o      = id_instr_q[6:0];
    assign PC_o          = id_pc_q;
    assign PC_Plus4_o    = id_pc_q + XLEN'(4);
    assign Instr_Valid_o = id_valid_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign Misalign_o    = misalign_q;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        skid_d    = skid_q;
        load      = 1'b0;
        load_data = skid_q;
        case (state_q)
            S_FETCH: begin
                if (Branch_Taken_i) pc_d = target;
                else if (Imem_Gnt_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (Branch_Taken_i) begin
                    pc_d    = target;
                    state_d = Imem_Rvalid_i ? S_FETCH : S_KILL;
                end else if (Imem_Rvalid_i) begin
                    if (!Stall_i) begin
                        load      = 1'b1;
                        load_data = Imem_Rdata_i;
                        pc_d      = pc_q + XLEN'(4);
                        state_d   = S_FETCH;
                    end else begin
                        skid_d  = Imem_Rdata_i;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (Branch_Taken_i) begin
                    pc_d    = target;
                    state_d = S_FETCH;
                end else if (!Stall_i) begin
                    load    = 1'b1;
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_FETCH;
                end
            end
            S_KILL: begin
                // A redirect coinciding with the drained response must not wait for another one.
                if (Branch_Taken_i) pc_d = target;
                if (Imem_Rvalid_i) state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase

`ifdef FETCH_MISALIGN_CHECK_EN
        misalign_d = misalign_q;
        if (Branch_Taken_i && (state_q != S_HALT) && (target[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
            state_d    = S_HALT;
        end
`endif

        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        if (Branch_Taken_i) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end else if (load) begin
            id_valid_d = 1'b1;
            id_instr_d = load_data;
            id_pc_d    = pc_q;
        end else if (!Stall_i) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            id_pc_q    <= '0;
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
            skid_q     <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            id_valid_q <= id_valid_d;
            skid_q     <= skid_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: transaction-level memory/decode model, directed cases then random traffic.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk, reset;
    logic        Stall_i, Branch_Taken_i;
    logic [31:0] Branch_Target_i;
    logic        Imem_Req_o, Imem_Gnt_i, Imem_Rvalid_i;
    logic [31:0] Imem_Addr_o, Imem_Rdata_i;
    logic [31:0] Instr_o, PC_o, PC_Plus4_o;
    logic [6:0]  Opcode_o;
    logic        Instr_Valid_o;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        Misalign_o;
`endif

    instruction_fetch_unit #(
        .XLEN(32),
        .RESET_PC(RESET_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Stall_i(Stall_i),
        .Branch_Taken_i(Branch_Taken_i),
        .Branch_Target_i(Branch_Target_i),
        .Imem_Req_o(Imem_Req_o),
        .Imem_Addr_o(Imem_Addr_o),
        .Imem_Gnt_i(Imem_Gnt_i),
        .Imem_Rvalid_i(Imem_Rvalid_i),
        .Imem_Rdata_i(Imem_Rdata_i),
        .Instr_o(Instr_o),
        .Opcode_o(Opcode_o),
        .PC_o(PC_o),
        .PC_Plus4_o(PC_Plus4_o),
        .Instr_Valid_o(Instr_Valid_o)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .Misalign_o(Misalign_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // stimulus knobs
    bit          stall, br, force_rv;
    logic [31:0] tgt;
    int unsigned gnt_pct, lat_min, lat_max;

    // memory model: at most one request in flight
    bit          out_any, out_live;
    logic [31:0] out_addr;
    int unsigned out_cnt;

    // decode-side model
    logic [31:0] fetch_pc;
    bit          h_valid;
    logic [31:0] h_pc, h_data;
    bit          m_valid;
    logic [31:0] m_pc, m_instr;
    bit          halted, mis;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h0000_0033;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_ifid(input string tag);
        chk1({tag, "_valid"}, Instr_Valid_o, m_valid);
        chk32({tag, "_instr"}, Instr_o, m_instr);
        chk32({tag, "_opcode"}, {25'b0, Opcode_o}, {25'b0, m_instr[6:0]});
        if (m_valid) begin
            chk32({tag, "_pc"}, PC_o, m_pc);
            chk32({tag, "_pc4"}, PC_Plus4_o, m_pc + 32'd4);
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        chk1({tag, "_misalign"}, Misalign_o, mis);
`endif
    endtask

    task automatic check_reset(input string tag);
        chk1({tag, "_valid"}, Instr_Valid_o, 1'b0);
        chk32({tag, "_instr"}, Instr_o, NOP);
        chk32({tag, "_opcode"}, {25'b0, Opcode_o}, 32'h13);
        chk32({tag, "_pc"}, PC_o, 32'h0);
        chk32({tag, "_pc4"}, PC_Plus4_o, 32'h4);
        chk1({tag, "_req"}, Imem_Req_o, 1'b0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk1({tag, "_misalign"}, Misalign_o, 1'b0);
`endif
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        Stall_i = 1'b0; Branch_Taken_i = 1'b0; Branch_Target_i = '0;
        Imem_Gnt_i = 1'b0; Imem_Rvalid_i = 1'b0; Imem_Rdata_i = '0;
        out_any = 0; out_live = 0; h_valid = 0; halted = 0; mis = 0;
        m_valid = 0; m_instr = NOP; m_pc = '0; fetch_pc = RESET_PC;
        #1 check_reset("rst_async");
        @(posedge clk); #1;
        check_reset("rst_hold");
        reset = 1'b0;
    endtask

    // One clock: drive memory + stimulus, check request side before the edge, IF/ID after it.
    task automatic cycle();
        bit          exp_req, grant, rv, resp;
        logic [31:0] r_pc, r_data;
        rv = (out_any && out_cnt == 1) || force_rv;
        Imem_Rvalid_i   = rv;
        Imem_Rdata_i    = (rv && out_any && out_live) ? mem_word(out_addr) : 32'hDEAD_BEEF;
        Imem_Gnt_i      = ($urandom_range(99) < gnt_pct);
        Stall_i         = stall;
        Branch_Taken_i  = br;
        Branch_Target_i = tgt;
        @(negedge clk);
        exp_req = !out_any && !h_valid && !halted;
        chk1("req", Imem_Req_o, exp_req);
        if (exp_req) chk32("addr", Imem_Addr_o, fetch_pc);
        grant  = exp_req && Imem_Gnt_i && !br;
        resp   = rv && out_any && out_live && !br && !halted;
        r_pc   = out_addr;
        r_data = mem_word(out_addr);

        if (out_any) begin
            if (rv) out_any = 0;
            else out_cnt--;
            if (br) out_live = 0;
        end
        if (grant) begin
            out_any  = 1;
            out_live = 1;
            out_addr = fetch_pc;
            out_cnt  = $urandom_range(lat_max, lat_min);
        end

        if (br) begin
            m_valid = 0;
            m_instr = NOP;
            if (!halted) begin
                h_valid = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
                fetch_pc = tgt;
                if (tgt[1:0] != 2'b00) begin
                    halted = 1;
                    mis    = 1;
                end
`else
                fetch_pc = tgt & ~32'd3;
`endif
            end
        end else if (stall) begin
            if (resp) begin
                h_valid = 1; h_pc = r_pc; h_data = r_data;
            end
        end else if (h_valid) begin
            m_valid = 1; m_pc = h_pc; m_instr = h_data; h_valid = 0;
        end else if (resp) begin
            m_valid = 1; m_pc = r_pc; m_instr = r_data;
        end else begin
            m_valid = 0; m_instr = NOP;
        end
        if (resp) fetch_pc = r_pc + 32'd4;

        @(posedge clk); #1;
        check_ifid("ifid");
    endtask

    task automatic step(input bit st, input bit b, input logic [31:0] t);
        stall = st; br = b; tgt = t;
        cycle();
    endtask

    initial begin
        bit found;
        stall = 0; br = 0; tgt = '0; force_rv = 0;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        apply_reset();

        // first fetch after reset release
        step(0, 0, '0);
        chk1("t1_bubble", Instr_Valid_o, 1'b0);
        step(0, 0, '0);
        chk1("t1_valid", Instr_Valid_o, 1'b1);
        chk32("t1_pc", PC_o, 32'h0040_0000);
        chk32("t1_opcode", {25'b0, Opcode_o}, 32'h33);
        chk32("t1_next_addr", Imem_Addr_o, 32'h0040_0004);

        // three stalled cycles, next response parked in the skid entry
        for (int unsigned i = 0; i < 3; i++) begin
            step(1, 0, '0);
            chk32("t2_hold_pc", PC_o, 32'h0040_0000);
            chk1("t2_hold_valid", Instr_Valid_o, 1'b1);
        end
        step(0, 0, '0);
        chk32("t2_release_pc", PC_o, 32'h0040_0004);
        step(0, 0, '0);
        step(0, 0, '0);
        chk32("t2_next_pc", PC_o, 32'h0040_0008);

        // redirect while waiting, stale response arrives two cycles later
        lat_min = 3; lat_max = 3;
        step(0, 0, '0);
        step(0, 1, 32'h0040_0100);
        step(0, 0, '0);
        lat_min = 1; lat_max = 1;
        step(0, 0, '0);
        chk32("t3_instr", Instr_o, NOP);
        chk1("t3_req", Imem_Req_o, 1'b1);
        chk32("t3_addr", Imem_Addr_o, 32'h0040_0100);
        step(0, 0, '0);
        step(0, 0, '0);
        chk32("t3_pc", PC_o, 32'h0040_0100);

        // redirect overrides stall
        step(1, 1, 32'h0040_0200);
        chk1("t4_valid", Instr_Valid_o, 1'b0);
        chk32("t4_instr", Instr_o, NOP);
        chk32("t4_addr", Imem_Addr_o, 32'h0040_0200);
        step(0, 0, '0);
        step(0, 0, '0);
        chk32("t4_pc", PC_o, 32'h0040_0200);

        // PC wrap
        step(0, 1, 32'hFFFF_FFFC);
        found = 0;
        for (int unsigned i = 0; i < 10 && !found; i++) begin
            step(0, 0, '0);
            if (Instr_Valid_o === 1'b1 && PC_o === 32'hFFFF_FFFC) found = 1;
        end
        chk1("t5_seen", found, 1'b1);
        chk32("t5_wrap_addr", Imem_Addr_o, 32'h0);
        chk32("t5_pc4", PC_Plus4_o, 32'h0);

        // misaligned redirect target
        step(0, 1, 32'h0040_0102);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk1("t6_misalign", Misalign_o, 1'b1);
        for (int unsigned i = 0; i < 4; i++) begin
            step(0, 0, '0);
            chk1("t6_halt_req", Imem_Req_o, 1'b0);
        end
        apply_reset();
`else
        chk32("t6_aligned_addr", Imem_Addr_o, 32'h0040_0100);
`endif

        // reset in the middle of a request, stale rvalid afterwards
        lat_min = 2; lat_max = 2;
        step(0, 0, '0);
        step(0, 0, '0);
        apply_reset();
        gnt_pct = 0; force_rv = 1;
        step(0, 0, '0);
        force_rv = 0; gnt_pct = 100; lat_min = 1; lat_max = 1;
        step(0, 0, '0);
        step(0, 0, '0);
        chk32("t7_pc", PC_o, 32'h0040_0000);
        chk32("t7_instr", Instr_o, 32'h0000_0033);

        // random traffic
        gnt_pct = 70; lat_min = 1; lat_max = 3;
        for (int unsigned i = 0; i < 800; i++) begin
            logic [31:0] t;
            case ($urandom_range(3))
                0:       t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                1:       t = RESET_PC + ($urandom & 32'hFF);
                default: t = $urandom;
            endcase
`ifdef FETCH_MISALIGN_CHECK_EN
            t = t & ~32'd3;
`endif
            step($urandom_range(9) < 3, $urandom_range(99) < 8, t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
